if_fetch_queue: RTL and testbench

- Parametrised instruction-fetch stage with a prefetch queue.
- Runs ahead of decode: issues sequential single-outstanding reads to the instruction memory port and buffers {pc, instruction} pairs in a DEPTH-entry FIFO.
- Supports taken-branch/JSR redirect with queue flush and discard of an in-flight response.
- Sits between the instruction-memory port and the decode stage; replaces the unbuffered fetch stage.

---
 rtl/if_fetch_queue.sv | 124 ++++++++++++
 tb/tb_if_fetch_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue of {pc, instruction} pairs.
// Issues single-outstanding sequential reads and supports redirect with flush.
module if_fetch_queue #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       mem_read,
  output logic [WIDTH-1:0]           mem_address,
  input  logic                       mem_resp,
  input  logic [WIDTH-1:0]           mem_rdata,
  input  logic                       redirect_en,
  input  logic [WIDTH-1:0]           redirect_pc,
  input  logic                       deq,
  output logic                       valid_out,
  output logic [WIDTH-1:0]           instr_out,
  output logic [WIDTH-1:0]           pc_out,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam int unsigned   PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] drop_addr_q, drop_addr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [WIDTH-1:0] pc_mem_q [DEPTH];
  logic [WIDTH-1:0] pc_mem_d [DEPTH];
  logic [WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WIDTH-1:0] instr_mem_d [DEPTH];
  logic             do_push;
  logic             do_deq;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    do_push     = (state_q == REQ) && mem_resp;
    do_deq      = deq && (count_q != '0);

    if (redirect_en) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc;
      unique case (state_q)
        REQ: begin
          if (mem_resp) begin
            state_d = IDLE;
          end else begin
            state_d     = DROP;
            drop_addr_d = fetch_pc_q;
          end
        end
        // A response landing in the same cycle retires the dropped request.
        DROP:    state_d = mem_resp ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      if (do_push) begin
        pc_mem_d[tail_q]    = fetch_pc_q;
        instr_mem_d[tail_q] = mem_rdata;
        tail_d              = tail_q + PW'(1);
        fetch_pc_d          = fetch_pc_q + WIDTH'(2);
      end
      if (do_deq) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_deq);
      unique case (state_q)
        IDLE:    state_d = (count_d < FULL) ? REQ : IDLE;
        REQ:     if (mem_resp) state_d = (count_d < FULL) ? REQ : IDLE;
        DROP:    if (mem_resp) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  assign mem_read    = (state_q != IDLE);
  assign mem_address = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
  assign valid_out   = (count_q != '0);
  assign stall       = ~valid_out;
  assign count_out   = count_q;
  assign instr_out   = instr_mem_q[head_q];
  assign pc_out      = pc_mem_q[head_q];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a latency-configurable memory model feeds the DUT,
// live responses are queued as expected entries and compared when decode dequeues.
module tb_if_fetch_queue;

  localparam int unsigned   DEPTH    = 4;
  localparam logic [15:0]   RESET_PC = 16'h0000;
  localparam int            BOUND    = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        deq;
  logic        valid_out;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        stall;
  logic [2:0]  count_out;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] exp_pc;
  logic [15:0] drop_addr;
  logic        dropping;
  int          lat;
  int          wait_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  if_fetch_queue #(
    .WIDTH(16),
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_read(mem_read),
    .mem_address(mem_address),
    .mem_resp(mem_resp),
    .mem_rdata(mem_rdata),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .deq(deq),
    .valid_out(valid_out),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .stall(stall),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check occupancy, answer the memory port, update the scoreboard.
  task automatic step();
    ent_t e;
    mem_resp = 1'b0;
    if (!reset) begin
      check("count_out", 32'(count_out), 32'(sb.size()));
      check("valid_out", 32'(valid_out), 32'(sb.size() != 0));
      check("stall", 32'(stall), 32'(sb.size() == 0));
      if (mem_read) begin
        check("mem_address", 32'(mem_address), 32'(dropping ? drop_addr : exp_pc));
        if (!dropping) check("req_room", 32'(sb.size() < DEPTH), 32'd1);
        if (wait_cnt + 1 >= lat) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_address ^ 16'hC3A5;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (deq && sb.size() != 0) begin
        e = sb[0];
        check("pc_out", 32'(pc_out), 32'(e.pc));
        check("instr_out", 32'(instr_out), 32'(e.instr));
        if (!redirect_en) void'(sb.pop_front());
      end
      if (redirect_en) begin
        if (mem_read && !mem_resp && !dropping) begin
          dropping  = 1'b1;
          drop_addr = exp_pc;
        end else if (mem_resp) begin
          dropping = 1'b0;
        end
        sb.delete();
        exp_pc = redirect_pc;
      end else if (mem_resp) begin
        if (dropping) begin
          dropping = 1'b0;
        end else begin
          sb.push_back('{exp_pc, mem_rdata});
          exp_pc = exp_pc + 16'd2;
        end
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      sb.delete();
      dropping = 1'b0;
      exp_pc   = RESET_PC;
      wait_cnt = 0;
    end
  endtask

  task automatic redirect_to(input logic [15:0] pc, input logic with_deq);
    redirect_en = 1'b1;
    redirect_pc = pc;
    deq         = with_deq;
    step();
    redirect_en = 1'b0;
    deq         = 1'b0;
  endtask

  task automatic wait_second_wait_cycle(input string tag);
    int n = 0;
    while (!(mem_read && !dropping && wait_cnt == 1) && n < BOUND) begin
      step();
      n++;
    end
    check(tag, 32'(n < BOUND), 32'd1);
  endtask

  task automatic wait_entries(input string tag, input int k);
    int n = 0;
    while (sb.size() < k && n < BOUND) begin
      step();
      n++;
    end
    check(tag, 32'(n < BOUND), 32'd1);
  endtask

  initial begin
    logic [15:0] old_addr;
    int          n;
    reset       = 1'b1;
    mem_resp    = 1'b0;
    mem_rdata   = '0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    deq         = 1'b0;
    lat         = 1;
    wait_cnt    = 0;
    dropping    = 1'b0;
    drop_addr   = '0;
    exp_pc      = RESET_PC;
    step();
    step();
    reset = 1'b0;

    // Reset state and fill with a single-cycle memory.
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_count", 32'(count_out), 32'd0);
    step();
    check("first_req", 32'(mem_read), 32'd1);
    check("first_addr", 32'(mem_address), 32'(RESET_PC));
    repeat (7) step();
    check("full_count", 32'(count_out), 32'd4);
    check("full_no_read", 32'(mem_read), 32'd0);
    check("full_pc_out", 32'(pc_out), 32'h0000);
    check("full_valid", 32'(valid_out), 32'd1);

    // One dequeue from full, refetch, then drain while fetching continues.
    deq = 1'b1;
    step();
    deq = 1'b0;
    check("deq_count", 32'(count_out), 32'd3);
    check("deq_pc_out", 32'(pc_out), 32'h0002);
    check("refetch_rd", 32'(mem_read), 32'd1);
    check("refetch_addr", 32'(mem_address), 32'h0008);
    repeat (3) step();
    deq = 1'b1;
    repeat (8) step();
    deq = 1'b0;

    // Redirect in the second wait cycle of a 3-cycle read.
    lat = 3;
    redirect_to(16'h1000, 1'b0);
    wait_second_wait_cycle("wait_req_a");
    old_addr = mem_address;
    redirect_to(16'h3000, 1'b0);
    check("drop_rd", 32'(mem_read), 32'd1);
    check("drop_addr", 32'(mem_address), 32'(old_addr));
    check("drop_count", 32'(count_out), 32'd0);
    wait_entries("wait_fill_a", 1);
    check("redir_pc_out", 32'(pc_out), 32'h3000);

    // Redirect coinciding with a response and a dequeue on a two-entry queue.
    lat = 1;
    n = 0;
    while (!(sb.size() == 2 && mem_read && !dropping) && n < BOUND) begin
      step();
      n++;
    end
    check("wait_two", 32'(n < BOUND), 32'd1);
    redirect_to(16'h4000, 1'b1);
    check("flush_count", 32'(count_out), 32'd0);
    check("flush_valid", 32'(valid_out), 32'd0);
    wait_entries("wait_fill_b", 1);
    check("flush_pc_out", 32'(pc_out), 32'h4000);

    // Address wrap from 0xFFFE.
    redirect_to(16'hFFFE, 1'b0);
    wait_entries("wait_fill_c", 2);
    check("wrap_pc0", 32'(pc_out), 32'hFFFE);
    deq = 1'b1;
    step();
    deq = 1'b0;
    check("wrap_pc1", 32'(pc_out), 32'h0000);

    // Reset while a dropped request is still outstanding.
    lat = 3;
    wait_second_wait_cycle("wait_req_b");
    redirect_to(16'h5000, 1'b0);
    check("drop2_rd", 32'(mem_read), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_mem_read", 32'(mem_read), 32'd0);
    check("rst2_count", 32'(count_out), 32'd0);
    check("rst2_valid", 32'(valid_out), 32'd0);
    step();
    check("rst2_req", 32'(mem_read), 32'd1);
    check("rst2_addr", 32'(mem_address), 32'(RESET_PC));
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
